// File: rtl/mips_pkg.sv
// Shared fetch/decode definitions: word width, default queue depth, NOP encoding
// and the fetch-entry record carried from IF to ID.
package mips_pkg;

  localparam int WORD_W    = 32;
  localparam int IFQ_DEPTH = 4;

  localparam logic [WORD_W-1:0] NOP = 32'b0;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_queue_mem.sv
// Entry storage for the IF/ID queue: one synchronous write port and one
// asynchronous read port. Contents are never reset; occupancy lives in the control.
module if_queue_mem #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: pointer and occupancy control around if_queue_mem.
// Optional empty-queue bypass is enabled by defining IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
  parameter int DEPTH  = mips_pkg::IFQ_DEPTH,
  parameter int WORD_W = mips_pkg::WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WORD_W-1:0]        in_pc,
  input  logic [WORD_W-1:0]        in_instr,
  output logic                     in_ready,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WORD_W-1:0]        out_pc,
  output logic [WORD_W-1:0]        out_instr,
  output logic [$clog2(DEPTH):0]   count
);
  import mips_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [WORD_W-1:0] NOP_W    = WORD_W'(NOP);

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                empty, full;
  logic                push, pop, bypass;
  logic [2*WORD_W-1:0] head;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

`ifdef IF_ID_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming entry; if it is consumed now it is never stored.
  assign bypass = empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push = in_valid && !full && !flush && !(bypass && out_ready);
  assign pop  = !empty && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  if_queue_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (2*WORD_W),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_pc, in_instr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    out_pc    = NOP_W;
    out_instr = NOP_W;
    if (!empty) begin
      out_pc    = head[2*WORD_W-1:WORD_W];
      out_instr = head[WORD_W-1:0];
    end else if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
  end

  assign out_valid = !empty || bypass;
  assign in_ready  = !full;
  assign count     = count_q;

endmodule
